encoder8x3_pending: RTL and testbench

Pending-request 8-to-3 priority encoder: the encode-side counterpart of the team's 3-to-8 decoders. Eight single-cycle request lines are captured into a sticky pending register, the winning request is presented as a 3-bit index under a valid/ready handshake, and each accepted index clears its pending bit. It sits between event sources (interrupt-style strobes) and a consumer that services one index at a time, typically feeding a 3x8 decoder on the far side.

---
 rtl/encoder8x3_pending.sv | 91 +++++++++
 tb/tb_encoder8x3_pending.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder8x3_pending.sv
// encoder8x3_pending: eight sticky request lines feed a pending register.
// The winning pending index is offered under valid/ready, and each accepted
// index clears its pending bit. A request that arrives on a bit which is
// already pending raises a one-cycle ovf pulse.
module encoder8x3_pending #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [7:0] in_i,
  input  logic       ready_i,
  output logic [2:0] out_o,
  output logic       valid_o,
  output logic [3:0] cnt_o,
  output logic       ovf_o
);

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 4;

  logic [N-1:0]  pending_q, pending_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic [IW-1:0] win_idx;
  logic          any_pending;
  logic          valid_c;
  logic [IW-1:0] out_c;
  logic          fire;
  logic [N-1:0]  ack_mask;
  logic [N-1:0]  cap;

  // Pick the winning pending index in the configured priority order.
  always_comb begin
    win_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < int'(N); i++) begin
        if (pending_q[i]) win_idx = IW'(i);
      end
    end else begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (pending_q[i]) win_idx = IW'(i);
      end
    end
  end

  // Present the winner. en gates valid directly, so dropping en hides the
  // index in the same cycle. out is held at zero whenever valid is low.
  always_comb begin
    any_pending = |pending_q;
    valid_c     = en_i & any_pending;
    out_c       = valid_c ? win_idx : '0;
  end

  // Work out the accept and capture masks, the next pending value, the
  // overflow flag and the population count.
  always_comb begin
    fire      = valid_c & ready_i;
    ack_mask  = fire ? (N'(1) << out_c) : '0;
    cap       = en_i ? in_i : '0;
    // A capture on the bit being accepted re-arms it (set wins over clear).
    pending_d = (pending_q & ~ack_mask) | cap;
    // Only a capture that hits a bit which stays pending counts as overflow.
    ovf_d     = |(cap & pending_q & ~ack_mask);
    cnt_d     = '0;
    for (int i = 0; i < int'(N); i++) begin
      cnt_d = cnt_d + CW'(pending_d[i]);
    end
  end

  // State registers. Reset clears every pending request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_o   = out_c;
  assign valid_o = valid_c;
  assign cnt_o   = cnt_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_encoder8x3_pending.sv
// Scoreboard bench for encoder8x3_pending. Two instances are driven with the
// same inputs: one in LSB-first order and one in MSB-first order.
// Each cycle the driver pushes the expected {valid,out,cnt,ovf} for that cycle.
// A monitor pops the expectation at the falling edge, compares it, and logs
// every accepted index so that drain orders can be checked against constants.
module tb_encoder8x3_pending;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] in_s;
  logic       ready;
  logic [2:0] out0, out1;
  logic       valid0, valid1;
  logic [3:0] cnt0, cnt1;
  logic       ovf0, ovf1;

  always #5 clk = ~clk;

  encoder8x3_pending #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .en_i(en), .in_i(in_s), .ready_i(ready),
    .out_o(out0), .valid_o(valid0), .cnt_o(cnt0), .ovf_o(ovf0)
  );

  encoder8x3_pending #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .en_i(en), .in_i(in_s), .ready_i(ready),
    .out_o(out1), .valid_o(valid1), .cnt_o(cnt1), .ovf_o(ovf1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expectation queues. Each entry is packed as {valid, out[2:0], cnt[3:0], ovf}.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int acc0[$];
  int acc1[$];

  // Reference state: the pending set as a plain integer, plus the overflow flag.
  int unsigned pend_m[2];
  bit          ovf_m[2];

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got v=%b out=%0d cnt=%0d ovf=%b, expected v=%b out=%0d cnt=%0d ovf=%b",
               nm, act[8], act[7:5], act[4:1], act[0], exp[8], exp[7:5], exp[4:1], exp[0]);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Lowest set bit comes from isolating it (p & -p). Highest set bit is
  // clog2(p+1) - 1.
  function automatic int winner(input int unsigned p, input bit msb);
    if (msb) return $clog2(p + 1) - 1;
    return $clog2(p & (~p + 1));
  endfunction

  function automatic logic [8:0] expect_now(input int k);
    bit v;
    int w;
    v = en && (pend_m[k] != 0);
    w = v ? winner(pend_m[k], k == 1) : 0;
    return {v, 3'(w), 4'($countones(pend_m[k])), ovf_m[k]};
  endfunction

  task automatic advance(input int k);
    bit v;
    int unsigned ack, cap;
    v   = en && (pend_m[k] != 0);
    ack = (v && ready) ? (32'd1 << winner(pend_m[k], k == 1)) : 32'd0;
    cap = en ? 32'(in_s) : 32'd0;
    ovf_m[k]  = (cap & pend_m[k] & ~ack) != 0;
    pend_m[k] = ((pend_m[k] & ~ack) | cap) & 32'hFF;
  endtask

  // Drive one cycle of stimulus starting just after a rising edge.
  task automatic step(input bit e, input logic [7:0] r, input bit rd);
    en = e; in_s = r; ready = rd;
    q0.push_back(expect_now(0));
    q1.push_back(expect_now(1));
    @(posedge clk); #1;
    advance(0);
    advance(1);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pend_m[k] = 0;
      ovf_m[k]  = 1'b0;
    end
  endtask

  task automatic chk_list(input string nm, input int got[$], input int exp[$]);
    chk_int({nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk_int(nm, got[i], exp[i]);
  endtask

  // Monitor: compare the DUT against the expectation for this cycle at the
  // falling edge, and log each accepted index.
  always @(negedge clk) begin
    if (q0.size() > 0) begin
      chk("lsb_cycle", {valid0, out0, cnt0, ovf0}, q0.pop_front());
      if (valid0 && ready) acc0.push_back(int'(out0));
    end
    if (q1.size() > 0) begin
      chk("msb_cycle", {valid1, out1, cnt1, ovf1}, q1.pop_front());
      if (valid1 && ready) acc1.push_back(int'(out1));
    end
  end

  initial begin
    int exp_a[$];
    int exp_b[$];
    logic [7:0] r;

    rst_n = 1'b0; en = 1'b0; in_s = 8'h00; ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_lsb", {valid0, out0, cnt0, ovf0}, 9'd0);
    chk("reset_msb", {valid1, out1, cnt1, ovf1}, 9'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Capture A4 once with ready held, then drain in priority order.
    acc0.delete(); acc1.delete();
    step(1'b1, 8'hA4, 1'b1);
    repeat (4) step(1'b1, 8'h00, 1'b1);
    exp_a = '{2, 5, 7};
    exp_b = '{7, 5, 2};
    chk_list("drain_a4_lsb", acc0, exp_a);
    chk_list("drain_a4_msb", acc1, exp_b);

    // Repeated request on a pending bit gives a single ovf pulse.
    step(1'b1, 8'h08, 1'b0);
    step(1'b1, 8'h08, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'h00, 1'b0);

    // Accepting and re-requesting the same bit in one cycle re-arms it.
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h01, 1'b1);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'h00, 1'b0);

    // en=0 ignores captures and blocks accepts. Then fill, overflow at full,
    // and drain.
    step(1'b1, 8'h10, 1'b0);
    step(1'b0, 8'hFF, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hFF, 1'b1);
    step(1'b1, 8'h81, 1'b0);
    acc0.delete(); acc1.delete();
    repeat (9) step(1'b1, 8'h00, 1'b1);
    exp_a = '{0, 1, 2, 3, 4, 5, 6, 7};
    exp_b = '{7, 6, 5, 4, 3, 2, 1, 0};
    chk_list("drain_full_lsb", acc0, exp_a);
    chk_list("drain_full_msb", acc1, exp_b);

    // Asynchronous reset in the middle of a drain.
    step(1'b1, 8'h30, 1'b0);
    step(1'b1, 8'h00, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midreset_lsb", {valid0, out0, cnt0, ovf0}, 9'd0);
    chk("midreset_msb", {valid1, out1, cnt1, ovf1}, 9'd0);
    model_reset();
    in_s = 8'h00;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (2) step(1'b1, 8'h00, 1'b1);

    // Randomised traffic.
    for (int c = 0; c < 2000; c++) begin
      r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      step($urandom_range(0, 7) != 0, r, $urandom_range(0, 2) != 0);
    end

    @(negedge clk);
    #1;
    chk_int("sb_drained_lsb", q0.size(), 0);
    chk_int("sb_drained_msb", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
